// File: rtl/ten_eth_tx_pkg.sv
// Shared types and constants for the 10G transmit buffer: egress FSM states,
// the per-frame descriptor queued alongside the data words, and keep helpers.
package ten_eth_pkg;

    localparam int         LEN_W    = 16;
    localparam logic [7:0] KEEP_ALL = 8'hFF;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [7:0]       keep;
    } tx_desc_t;

    localparam int DESC_W = $bits(tx_desc_t);

    // Only the final beat of a frame carries a partial byte mask.
    function automatic logic [7:0] beat_keep(input logic is_last, input logic [7:0] last_keep);
        return is_last ? last_keep : KEEP_ALL;
    endfunction

endpackage

// File: rtl/ten_eth_tx_if.sv
// 64-bit AXI-Stream bundle used for both the fabric ingress and the MAC egress.
interface ten_eth_tx_if;

    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic        tlast;
    logic [7:0]  tkeep;
    logic        tuser;

    modport master (
        output tvalid, tdata, tlast, tkeep, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tlast, tkeep, tuser,
        output tready
    );

endinterface

// File: rtl/ten_eth_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head word; a word
// written on one edge shows at the head after the following edge.
module ten_eth_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic wr_fire;
    logic pop;
    logic mem_empty;
    logic load;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        wr_fire   = wr_en_i && !full_q;
        pop       = rd_en_i && valid_q;
        mem_empty = (wr_ptr_q == rd_ptr_q);
        load      = !mem_empty && (!valid_q || pop);

        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, wr_fire};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, load};
        dout_d    = dout_q;
        valid_d   = valid_q;
        if (load) begin
            dout_d  = mem_q[rd_ptr_q[AW-1:0]];
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end

        // Occupancy includes the head register, so full means DEPTH words in total.
        count_d = count_q + {{AW{1'b0}}, wr_fire} - {{AW{1'b0}}, pop};
        full_d  = (count_d == CW'(DEPTH));
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            dout_q   <= dout_d;
        end
    end

    // NOTE: storage is not reset; pointers and the valid flag alone define contents.
    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    assign dout_o  = dout_q;
    assign full_o  = full_q;
    assign empty_o = !valid_q;

endmodule

// File: rtl/ten_eth_tx.sv
// Store-and-forward transmit buffer for one 10G port: queues whole frames from
// the fabric and replays them back-to-back to the MAC, dropping frames while link is down.
module ten_eth_tx
    import ten_eth_pkg::*;
#(
    parameter int P_DATA_DEPTH = 256,
    parameter int P_INFO_DEPTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stat_rx_status,
    ten_eth_tx_if.slave        s_axis,
    ten_eth_tx_if.master       m_axis_tx,
    output logic [15:0]        o_tx_frame_cnt,
    output logic [15:0]        o_drop_cnt
);

    localparam logic [0:0] S_IDLE = TX_IDLE;
    localparam logic [0:0] S_SEND = TX_SEND;

    logic        data_full, data_empty;
    logic        info_full, info_empty;
    logic [63:0] data_dout;
    tx_desc_t    info_din, info_dout;
    logic        data_wr, data_rd;
    logic        info_wr, info_rd;

    logic             in_frame_q, in_frame_d;
    logic             drop_q, drop_d;
    logic [LEN_W-1:0] wcnt_q, wcnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic [0:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [7:0]       keep_q, keep_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic s_ready, s_fire, drop_now;
    logic in_send, tx_last, tx_fire;
    logic unused_tuser;
    logic unused_data_empty;

    assign unused_tuser      = s_axis.tuser;
    assign unused_data_empty = data_empty;

    // Ingress: the link state seen on a frame's first beat decides keep-or-drop for the whole frame.
    always_comb begin
        s_ready  = !i_rst && !data_full && !info_full;
        s_fire   = s_axis.tvalid && s_ready;
        drop_now = in_frame_q ? drop_q : !i_stat_rx_status;
        data_wr  = s_fire && !drop_now;
        info_wr  = data_wr && s_axis.tlast;

        info_din.len  = wcnt_q + 16'd1;
        info_din.keep = s_axis.tkeep;

        in_frame_d = in_frame_q;
        drop_d     = drop_q;
        wcnt_d     = wcnt_q;
        drop_cnt_d = drop_cnt_q;
        if (s_fire) begin
            in_frame_d = !s_axis.tlast;
            drop_d     = drop_now;
            if (data_wr) begin
                wcnt_d = s_axis.tlast ? '0 : wcnt_q + 16'd1;
            end
            if (drop_now && s_axis.tlast) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // Egress: a descriptor is only taken while the link is up; once in SEND the frame always completes.
    always_comb begin
        in_send = (state_q == S_SEND);
        tx_last = in_send && (beat_q == len_q - 16'd1);
        tx_fire = in_send && m_axis_tx.tready;
        data_rd = tx_fire;
        info_rd = 1'b0;

        state_d     = state_q;
        len_d       = len_q;
        keep_d      = keep_q;
        beat_d      = beat_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (!info_empty && i_stat_rx_status) begin
                    len_d   = info_dout.len;
                    keep_d  = info_dout.keep;
                    beat_d  = '0;
                    info_rd = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_fire) begin
                    if (tx_last) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_IDLE;
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            in_frame_q  <= 1'b0;
            drop_q      <= 1'b0;
            wcnt_q      <= '0;
            drop_cnt_q  <= '0;
            state_q     <= S_IDLE;
            len_q       <= '0;
            keep_q      <= '0;
            beat_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            in_frame_q  <= in_frame_d;
            drop_q      <= drop_d;
            wcnt_q      <= wcnt_d;
            drop_cnt_q  <= drop_cnt_d;
            state_q     <= state_d;
            len_q       <= len_d;
            keep_q      <= keep_d;
            beat_q      <= beat_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    ten_eth_sync_fifo #(
        .WIDTH (64),
        .DEPTH (P_DATA_DEPTH)
    ) u_data_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en_i (data_wr),
        .din_i   (s_axis.tdata),
        .rd_en_i (data_rd),
        .dout_o  (data_dout),
        .full_o  (data_full),
        .empty_o (data_empty)
    );

    ten_eth_sync_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (P_INFO_DEPTH)
    ) u_info_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en_i (info_wr),
        .din_i   (info_din),
        .rd_en_i (info_rd),
        .dout_o  (info_dout),
        .full_o  (info_full),
        .empty_o (info_empty)
    );

    assign s_axis.tready = s_ready;

    // Outputs are forced to zero outside SEND so idle and reset present a quiet bus.
    assign m_axis_tx.tvalid = in_send;
    assign m_axis_tx.tdata  = in_send ? data_dout : 64'd0;
    assign m_axis_tx.tlast  = tx_last;
    assign m_axis_tx.tkeep  = in_send ? beat_keep(tx_last, keep_q) : 8'h00;
    assign m_axis_tx.tuser  = 1'b0;

    assign o_tx_frame_cnt = frame_cnt_q;
    assign o_drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_ten_eth_tx.sv
// Directed-random bench for ten_eth_tx: frames are modelled as queues of beats
// and every egress beat, latency, gap and counter is compared against that model.
module tb_ten_eth_tx;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        link;
    logic [15:0] tx_cnt;
    logic [15:0] drop_cnt;

    ten_eth_tx_if s_if ();
    ten_eth_tx_if m_if ();

    ten_eth_tx #(
        .P_DATA_DEPTH (256),
        .P_INFO_DEPTH (32)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stat_rx_status (link),
        .s_axis           (s_if.slave),
        .m_axis_tx        (m_if.master),
        .o_tx_frame_cnt   (tx_cnt),
        .o_drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    acc_words = 0;
    int    rdy_mode = 0;
    int    exp_tx = 0;
    int    exp_drop = 0;
    beat_t cap[$];
    beat_t exp_q[$];

    bit          mon_stall = 0;
    bit          mon_mid = 0;
    logic [72:0] mon_prev = '0;

    int t1, t2, t3, t_dummy, words_at_stall, low;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = 1'($urandom_range(0, 1));
            default: m_if.tready = 1'b0;
        endcase
    endtask

    // Send one frame; the link value seen on beat 0 decides whether the model expects it out.
    task automatic send_frame(input int nwords, input logic [7:0] lkeep, input logic link_first,
                              input int up_after, output int t_last);
        beat_t fr[$];
        logic  sent;
        bit    acc;
        sent   = (up_after > 0) ? link_first : 1'b1;
        t_last = -1;
        for (int i = 0; i < nwords; i++) begin
            acc         = 1'b0;
            s_if.tvalid = 1'b1;
            s_if.tdata  = {$urandom, $urandom};
            s_if.tlast  = (i == nwords - 1);
            s_if.tkeep  = (i == nwords - 1) ? lkeep : 8'hFF;
            s_if.tuser  = 1'($urandom_range(0, 1));
            link        = (i < up_after) ? link_first : 1'b1;
            for (int w = 0; w < 2000 && !acc; w++) begin
                @(negedge clk);
                acc = s_if.tready;
                if (acc) begin
                    acc_words++;
                    if (s_if.tlast) t_last = cyc;
                end
                if (acc) fr.push_back('{data: s_if.tdata, keep: s_if.tkeep, last: s_if.tlast, cyc: 0});
                tick();
            end
            if (!acc) begin
                check("ingress_timeout", 80'(acc), 80'd1);
                s_if.tvalid = 1'b0;
                return;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        if (sent) begin
            foreach (fr[k]) exp_q.push_back(fr[k]);
            exp_tx++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic wait_cap(input string tag, input int n);
        for (int w = 0; w < 3000 && cap.size() < n; w++) tick();
        check({tag, "_beats"}, 80'(cap.size()), 80'(n));
    endtask

    task automatic compare_frames(input string tag);
        check({tag, "_nbeats"}, 80'(cap.size()), 80'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < cap.size(); k++) begin
            check({tag, "_beat"}, {7'd0, cap[k].data, cap[k].keep, cap[k].last},
                  {7'd0, exp_q[k].data, exp_q[k].keep, exp_q[k].last});
        end
        check({tag, "_txcnt"}, 80'(tx_cnt), 80'(exp_tx[15:0]));
        check({tag, "_dropcnt"}, 80'(drop_cnt), 80'(exp_drop[15:0]));
        cap.delete();
        exp_q.delete();
    endtask

    // Egress monitor: records handshakes and checks AXIS hold/no-gap rules.
    always @(negedge clk) begin
        if (rst) begin
            mon_stall = 1'b0;
            mon_mid   = 1'b0;
        end else begin
            if (mon_stall) begin
                check("stall_valid", 80'(m_if.tvalid), 80'd1);
                check("stall_hold", 80'({m_if.tdata, m_if.tkeep, m_if.tlast}), 80'(mon_prev));
            end else if (mon_mid) begin
                check("no_gap", 80'(m_if.tvalid), 80'd1);
            end
            if (m_if.tvalid && m_if.tready) begin
                cap.push_back('{data: m_if.tdata, keep: m_if.tkeep, last: m_if.tlast, cyc: cyc});
                mon_mid   = !m_if.tlast;
                mon_stall = 1'b0;
            end else begin
                mon_stall = m_if.tvalid;
                mon_mid   = 1'b0;
                mon_prev  = {m_if.tdata, m_if.tkeep, m_if.tlast};
            end
        end
    end

    initial begin
        rst         = 1'b1;
        link        = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = '0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b0;

        // Reset state
        #2;
        check("rst_s_tready_early", 80'(s_if.tready), 80'd0);
        repeat (3) tick();
        check("rst_s_tready", 80'(s_if.tready), 80'd0);
        check("rst_tvalid", 80'(m_if.tvalid), 80'd0);
        check("rst_tdata", 80'(m_if.tdata), 80'd0);
        check("rst_tkeep", 80'(m_if.tkeep), 80'd0);
        check("rst_tlast", 80'(m_if.tlast), 80'd0);
        check("rst_tuser", 80'(m_if.tuser), 80'd0);
        check("rst_txcnt", 80'(tx_cnt), 80'd0);
        check("rst_dropcnt", 80'(drop_cnt), 80'd0);
        rst = 1'b0;
        tick();
        check("idle_s_tready", 80'(s_if.tready), 80'd1);

        // Single 8-word frame: latency T+3, 8 consecutive beats
        send_frame(8, 8'h0F, 1'b1, 0, t1);
        wait_cap("t1", 8);
        if (cap.size() >= 8) begin
            check("t1_latency", 80'(cap[0].cyc), 80'(t1 + 3));
            check("t1_burst", 80'(cap[7].cyc - cap[0].cyc), 80'd7);
        end
        compare_frames("t1");

        // Back-to-back 1, 190, 1 words: order, 1-word tlast, single idle gap
        send_frame(1, 8'h03, 1'b1, 0, t1);
        send_frame(190, 8'h3F, 1'b1, 0, t2);
        send_frame(1, 8'h01, 1'b1, 0, t3);
        wait_cap("t2", 192);
        if (cap.size() >= 192) begin
            check("t2_latency", 80'(cap[0].cyc), 80'(t1 + 3));
            check("t2_long_lat", 80'(cap[1].cyc), 80'(t2 + 3));
            check("t2_burst", 80'(cap[190].cyc - cap[1].cyc), 80'd189);
            check("t2_idle_gap", 80'(cap[191].cyc - cap[190].cyc), 80'd2);
        end
        compare_frames("t2");

        // Random MAC backpressure on a 64-word frame
        rdy_mode = 1;
        send_frame(64, 8'h07, 1'b1, 0, t1);
        wait_cap("t3", 64);
        rdy_mode = 0;
        compare_frames("t3");

        // Link down at frame start, up mid-frame: dropped; next frame sent
        send_frame(10, 8'hFF, 1'b0, 3, t_dummy);
        repeat (5) tick();
        check("t4_drop", 80'(drop_cnt), 80'd1);
        send_frame(12, 8'h1F, 1'b1, 0, t1);
        wait_cap("t4", 12);
        if (cap.size() >= 1) check("t4_latency", 80'(cap[0].cyc), 80'(t1 + 3));
        compare_frames("t4");

        // Fill the data FIFO with the MAC stalled, then drain
        rdy_mode  = 2;
        acc_words = 0;
        low       = 0;
        fork
            begin
                for (int f = 0; f < 5; f++) send_frame(64, 8'hFF, 1'b1, 0, t_dummy);
            end
            begin
                for (int c = 0; c < 1500 && low < 20; c++) begin
                    @(negedge clk);
                    low = s_if.tready ? 0 : low + 1;
                end
                words_at_stall = acc_words;
                rdy_mode = 0;
            end
        join
        check("t5_stall_seen", 80'(low >= 20), 80'd1);
        check("t5_fill_words", 80'(words_at_stall), 80'd256);
        wait_cap("t5", 320);
        compare_frames("t5");

        // Reset in the middle of SEND with a second frame queued
        send_frame(40, 8'hFF, 1'b1, 0, t1);
        send_frame(20, 8'h0F, 1'b1, 0, t2);
        check("t6_mid_send", 80'(m_if.tvalid), 80'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_tvalid", 80'(m_if.tvalid), 80'd0);
        check("t6_rst_txcnt", 80'(tx_cnt), 80'd0);
        check("t6_rst_dropcnt", 80'(drop_cnt), 80'd0);
        check("t6_rst_s_tready", 80'(s_if.tready), 80'd0);
        tick();
        rst = 1'b0;
        cap.delete();
        exp_q.delete();
        exp_tx   = 0;
        exp_drop = 0;
        repeat (100) tick();
        check("t6_no_replay", 80'(cap.size()), 80'd0);
        check("t6_idle_tvalid", 80'(m_if.tvalid), 80'd0);
        send_frame(5, 8'h03, 1'b1, 0, t1);
        wait_cap("t6", 5);
        if (cap.size() >= 1) check("t6_latency", 80'(cap[0].cyc), 80'(t1 + 3));
        compare_frames("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
